// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the MIPS pipeline control blocks: fetch start address,
// Tuse sentinel, mult/div tracker state encoding and default unit latencies.
package hazard_stall_ctrl_pkg;

  localparam logic [31:0] PC_START = 32'h0000_3000;

  // A Tuse of 3 exceeds every legal Tnew, so an unused operand never stalls.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// HI/LO unit busy tracker: busy is high for exactly N cycles, starting the
// cycle after a mult/div issues into EX (N = MULT_CYCLES or DIV_CYCLES).
module md_busy_tracker
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;

  // NOTE: state, counter and busy all update with <= in one clocked block so
  // every register samples pre-edge values; busy is registered, not decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state <= MD_BUSY;
            busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          // A start seen here is impossible in a legal program and is ignored.
          if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew data stalls plus HI/LO busy stalls.
// Define STALL_PERF_CNT_EN to add saturating stall_cycles/md_stall_cycles counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [1:0]  id_rs_tuse,
  input  logic [1:0]  id_rt_tuse,
  input  logic        id_md_use,
  input  logic [4:0]  ex_wa,
  input  logic [1:0]  ex_tnew,
  input  logic [4:0]  mem_wa,
  input  logic [1:0]  mem_tnew,
  input  logic        ex_md_start,
  input  logic        ex_md_div,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_clr,
  output logic        md_busy
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  logic stall_rs, stall_rt, stall_md, stall;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_tracker (
    .clk    (clk),
    .reset  (reset),
    .start  (ex_md_start),
    .is_div (ex_md_div),
    .busy   (md_busy)
  );

  // $0 is hard-wired, so a match on register 0 is never a real dependency.
  assign stall_rs = (id_rs != 5'd0) &&
                    ((id_rs == ex_wa  && ex_tnew  > id_rs_tuse) ||
                     (id_rs == mem_wa && mem_tnew > id_rs_tuse));
  assign stall_rt = (id_rt != 5'd0) &&
                    ((id_rt == ex_wa  && ex_tnew  > id_rt_tuse) ||
                     (id_rt == mem_wa && mem_tnew > id_rt_tuse));
  assign stall_md = id_md_use && (md_busy || ex_md_start);
  assign stall    = stall_rs | stall_rt | stall_md;

  assign pc_en    = ~stall;
  assign ifid_en  = ~stall;
  assign idex_clr = stall;

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (stall_md && md_stall_cycles != 32'hFFFF_FFFF)
        md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: data hazards, $0 immunity, mult/div
// busy window, ignored re-issue and mid-busy reset (plus perf counters if enabled).
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0] id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew;
  logic       id_md_use, ex_md_start, ex_md_div;
  logic       pc_en, ifid_en, idex_clr, md_busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_tuse  (id_rs_tuse),
    .id_rt_tuse  (id_rt_tuse),
    .id_md_use   (id_md_use),
    .ex_wa       (ex_wa),
    .ex_tnew     (ex_tnew),
    .mem_wa      (mem_wa),
    .mem_tnew    (mem_tnew),
    .ex_md_start (ex_md_start),
    .ex_md_div   (ex_md_div),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_clr    (idex_clr),
    .md_busy     (md_busy)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cycle_start;
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet;
    id_rs = 5'd8;  id_rt = 5'd9;
    id_rs_tuse = 2'd3; id_rt_tuse = 2'd3;
    id_md_use = 1'b0;
    ex_wa = 5'd20; ex_tnew = 2'd0;
    mem_wa = 5'd21; mem_tnew = 2'd0;
    ex_md_start = 1'b0; ex_md_div = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_quiet();
    repeat (2) cycle_start();
    @(negedge clk);
    n_cmp++;
    if (md_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_md_busy got %b want 0", md_busy);
    end
    n_cmp++;
    if ({pc_en, ifid_en, idex_clr} !== 3'b110) begin
      n_bad++; $display("FAIL reset_stall_outs got %b want 110", {pc_en, ifid_en, idex_clr});
    end
    cycle_start();
    reset = 1'b0;
  endtask

  task automatic test_no_hazard;
    for (int k = 0; k < 3; k++) begin
      cycle_start();
      set_quiet();
      id_rs = 5'd8; ex_wa = 5'd9; mem_wa = 5'd10;
      id_rs_tuse = 2'(k); id_rt_tuse = 2'd0;
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_clr} !== 3'b110) begin
        n_bad++; $display("FAIL no_hazard k=%0d got %b want 110", k, {pc_en, ifid_en, idex_clr});
      end
    end
  endtask

  // Rows: rs, rt, rs_tuse, rt_tuse, ex_wa, ex_tnew, mem_wa, mem_tnew, expected stall.
  task automatic test_data_hazard;
    logic [4:0] rs_v[8], rt_v[8], exw_v[8], memw_v[8];
    logic [1:0] rsu_v[8], rtu_v[8], ext_v[8], memt_v[8];
    logic       exp_v[8];
    rs_v  = '{8, 8, 8, 8, 1, 1, 1, 1};
    rt_v  = '{9, 9, 9, 9, 12, 12, 12, 12};
    rsu_v = '{0, 0, 0, 1, 3, 3, 3, 3};
    rtu_v = '{3, 3, 3, 3, 1, 1, 3, 2};
    exw_v = '{8, 20, 20, 8, 20, 12, 12, 20};
    ext_v = '{2, 0, 0, 1, 0, 2, 3, 0};
    memw_v = '{21, 8, 8, 21, 12, 21, 21, 12};
    memt_v = '{0, 1, 0, 0, 2, 0, 0, 3};
    exp_v = '{1, 1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < 8; k++) begin
      cycle_start();
      set_quiet();
      id_rs = rs_v[k]; id_rt = rt_v[k];
      id_rs_tuse = rsu_v[k]; id_rt_tuse = rtu_v[k];
      ex_wa = exw_v[k]; ex_tnew = ext_v[k];
      mem_wa = memw_v[k]; mem_tnew = memt_v[k];
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_clr} !== {~exp_v[k], ~exp_v[k], exp_v[k]}) begin
        n_bad++;
        $display("FAIL data_hazard row=%0d got %b want %b", k,
                 {pc_en, ifid_en, idex_clr}, {~exp_v[k], ~exp_v[k], exp_v[k]});
      end
    end
  endtask

  task automatic test_zero_reg;
    for (int k = 0; k < 2; k++) begin
      cycle_start();
      set_quiet();
      if (k == 0) begin
        id_rt = 5'd0; id_rt_tuse = 2'd0; ex_wa = 5'd0; ex_tnew = 2'd2;
      end else begin
        id_rs = 5'd0; id_rs_tuse = 2'd0; mem_wa = 5'd0; mem_tnew = 2'd3;
      end
      @(negedge clk);
      n_cmp++;
      if ({pc_en, ifid_en, idex_clr} !== 3'b110) begin
        n_bad++; $display("FAIL zero_reg k=%0d got %b want 110", k, {pc_en, ifid_en, idex_clr});
      end
    end
  endtask

  // Issue at cycle 0; busy expected over cycles 1..n, stall over 0..n when id_md_use is held.
  task automatic run_md(input logic is_div, input int n, input logic use_md,
                        input int reissue_at, input string tag);
    logic exp_busy, exp_stall;
    for (int k = 0; k <= n + 2; k++) begin
      cycle_start();
      set_quiet();
      id_md_use = use_md;
      ex_md_start = (k == 0) || (k == reissue_at);
      ex_md_div = (k == 0) ? is_div : ~is_div;
      @(negedge clk);
      exp_busy = (k >= 1) && (k <= n);
      exp_stall = use_md && (k <= n || k == reissue_at);
      n_cmp++;
      if (md_busy !== exp_busy) begin
        n_bad++; $display("FAIL %s md_busy k=%0d got %b want %b", tag, k, md_busy, exp_busy);
      end
      n_cmp++;
      if ({pc_en, ifid_en, idex_clr} !== {~exp_stall, ~exp_stall, exp_stall}) begin
        n_bad++;
        $display("FAIL %s stall k=%0d got %b want %b", tag, k,
                 {pc_en, ifid_en, idex_clr}, {~exp_stall, ~exp_stall, exp_stall});
      end
    end
  endtask

  task automatic test_mult_busy;
    run_md(1'b0, 5, 1'b1, -1, "mult");
  endtask

  task automatic test_div_back_to_back;
    run_md(1'b1, 10, 1'b0, 3, "div_reissue");
  endtask

  task automatic test_div_mid_reset;
    logic exp_busy;
    for (int k = 0; k <= 6; k++) begin
      cycle_start();
      set_quiet();
      ex_md_start = (k == 0);
      ex_md_div = 1'b1;
      reset = (k == 4);
      @(negedge clk);
      exp_busy = (k >= 1) && (k <= 4);
      n_cmp++;
      if (md_busy !== exp_busy) begin
        n_bad++; $display("FAIL div_reset md_busy k=%0d got %b want %b", k, md_busy, exp_busy);
      end
    end
    run_md(1'b0, 5, 1'b1, -1, "mult_after_reset");
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf_cnt;
    cycle_start();
    set_quiet();
    reset = 1'b1;
    cycle_start();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      id_rs = 5'd8; id_rs_tuse = 2'd0; ex_wa = 5'd8; ex_tnew = 2'd2;
      cycle_start();
    end
    set_quiet();
    ex_md_start = 1'b1;
    cycle_start();
    ex_md_start = 1'b0;
    id_md_use = 1'b1;
    repeat (4) cycle_start();
    id_md_use = 1'b0;
    repeat (3) cycle_start();
    @(negedge clk);
    n_cmp++;
    if (stall_cycles !== 32'd7) begin
      n_bad++; $display("FAIL perf_stall_cycles got %0d want 7", stall_cycles);
    end
    n_cmp++;
    if (md_stall_cycles !== 32'd4) begin
      n_bad++; $display("FAIL perf_md_stall_cycles got %0d want 4", md_stall_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_no_hazard();
    test_data_hazard();
    test_zero_reg();
    test_mult_busy();
    test_div_back_to_back();
    test_div_mid_reset();
`ifdef STALL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
